program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program image loader into instruction memory
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        program_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  cnt_q, cnt_d;

  // Bytes arrive least-significant first, so each new byte enters at the top
  // and the first byte ends up in bits [7:0] after four shifts.
  logic [31:0] word_shift;
  logic        hs;

  assign word_shift = {rx_data, word_q[31:8]};

  // Next-state, counters and outputs; program_reset overrides every state.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    word_d    = word_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    imem_we   = 1'b0;
    imem_addr = 32'h0;
    imem_wd   = 32'h0;
    done      = 1'b0;
    error     = 1'b0;

    // Not ready while program_reset is high so an abandoned load never eats a byte.
    rx_ready = !program_reset &&
               ((state_q == LEN) || (state_q == DATA) || (state_q == CHK));
    hs = rx_valid && rx_ready;

    case (state_q)
      IDLE: begin
        n_d    = 32'h0;
        idx_d  = 32'h0;
        word_d = 32'h0;
        csum_d = 8'h0;
        cnt_d  = 2'd0;
        state_d = LEN;
      end
      LEN: begin
        if (hs) begin
          word_d = word_shift;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            n_d = word_shift;
            if (word_shift > 32'(MAX_WORDS)) begin
              state_d = ERR;
            end else if (word_shift == 32'h0) begin
              state_d = CHK;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (hs) begin
          word_d = word_shift;
          csum_d = csum_q ^ rx_data;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        imem_we   = 1'b1;
        imem_addr = ADDR_BASE + {idx_q[29:0], 2'b00};
        imem_wd   = word_q;
        idx_d     = idx_q + 32'd1;
        state_d   = ((idx_q + 32'd1) == n_q) ? CHK : DATA;
      end
      CHK: begin
        if (hs) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (program_reset) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 32'h0;
      idx_q   <= 32'h0;
      word_q  <= 32'h0;
      csum_q  <= 8'h0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
